// File: rtl/arb_pkg.sv
// Shared types, defaults and helpers for the round-robin hold arbiter.
package arb_pkg;

  localparam int unsigned ARB_N        = 4;
  localparam int unsigned ARB_MAX_HOLD = 8;
  // Widest requester vector the index helper understands.
  localparam int unsigned ARB_MAX_N    = 16;

  typedef enum logic {
    StIdle,
    StOwned
  } arb_state_e;

  // One-hot (bit 0 first) to binary index; all-zero input yields 0.
  function automatic logic [3:0] onehot_to_idx(input logic [0:ARB_MAX_N-1] oh);
    logic [3:0] idx;
    idx = '0;
    for (int i = 0; i < ARB_MAX_N; i++) begin
      if (oh[i]) idx = idx | 4'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_priority_chain.sv
// Rotating-priority daisy chain: first unmasked request at or after ptr_i wins.
module rr_priority_chain
  import arb_pkg::*;
#(
  parameter int unsigned N   = ARB_N,
  parameter int unsigned IDW = $clog2(N)
) (
  input  logic [0:N-1]   req_i,
  input  logic [0:N-1]   mask_i,
  input  logic [IDW-1:0] ptr_i,
  output logic [0:N-1]   win_o,
  output logic           any_o
);

  localparam int NI = int'(N);

  logic [0:N-1]   req_m;
  logic [0:2*N-1] dbl;
  logic [0:2*N-1] win_dbl;
  logic           carry;

  // Walk the doubled vector from ptr for N positions, then fold back onto N bits.
  always_comb begin
    req_m   = req_i & ~mask_i;
    dbl     = {req_m, req_m};
    win_dbl = '0;
    carry   = 1'b0;
    for (int k = 0; k < 2 * NI; k++) begin
      if (k >= int'(ptr_i) && k < int'(ptr_i) + NI && !carry && dbl[k]) begin
        win_dbl[k] = 1'b1;
        carry      = 1'b1;
      end
    end
    win_o = win_dbl[0:N-1] | win_dbl[N:2*N-1];
    any_o = |req_m;
  end

endmodule

// File: rtl/rr_hold_arbiter.sv
// Registered round-robin arbiter with grant hold and a contention hold limit.
module rr_hold_arbiter
  import arb_pkg::*;
#(
  parameter int unsigned N        = ARB_N,
  parameter int unsigned MAX_HOLD = ARB_MAX_HOLD,
  parameter int unsigned IDW      = $clog2(N)
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [0:N-1]   req_i,
  output logic [0:N-1]   gnt_o,
  output logic           gnt_valid_o,
  output logic [IDW-1:0] gnt_id_o,
  output logic           preempt_o
);

  localparam int unsigned    HCW      = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam bit             LimitEn  = (MAX_HOLD != 0);
  localparam logic [HCW-1:0] HoldLast = LimitEn ? HCW'(MAX_HOLD - 1) : '0;
  localparam logic [IDW-1:0] LastIdx  = IDW'(N - 1);

  arb_state_e           state_q, state_d;
  logic [0:N-1]         gnt_q, gnt_d;
  logic [IDW-1:0]       gnt_id_q, gnt_id_d;
  logic [IDW-1:0]       ptr_q, ptr_d;
  logic [HCW-1:0]       hold_q, hold_d;
  logic                 preempt_q, preempt_d;

  logic [IDW-1:0]       owner_inc;
  logic                 owner_req;
  logic [IDW-1:0]       chain_ptr;
  logic [0:N-1]         chain_mask;
  logic [0:N-1]         win;
  logic                 any_win;
  logic [0:ARB_MAX_N-1] win_pad;
  logic [IDW-1:0]       win_idx;

  // While owned, search starts after the owner with the owner masked out, so
  // the same chain result serves release, timeout and the "others waiting" test.
  assign owner_inc  = (gnt_id_q == LastIdx) ? '0 : gnt_id_q + 1'b1;
  assign owner_req  = |(req_i & gnt_q);
  assign chain_ptr  = (state_q == StOwned) ? owner_inc : ptr_q;
  assign chain_mask = (state_q == StOwned) ? gnt_q : '0;

  rr_priority_chain #(
    .N   (N),
    .IDW (IDW)
  ) u_chain (
    .req_i  (req_i),
    .mask_i (chain_mask),
    .ptr_i  (chain_ptr),
    .win_o  (win),
    .any_o  (any_win)
  );

  // Binary index of the chain winner.
  always_comb begin
    win_pad        = '0;
    win_pad[0:N-1] = win;
    win_idx        = IDW'(onehot_to_idx(win_pad));
  end

  // Next-state: grant from idle, release, timeout, sole-owner saturation, hold.
  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    gnt_id_d  = gnt_id_q;
    ptr_d     = ptr_q;
    hold_d    = hold_q;
    preempt_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (any_win) begin
          gnt_d    = win;
          gnt_id_d = win_idx;
          hold_d   = '0;
          state_d  = StOwned;
        end
      end
      StOwned: begin
        if (!owner_req) begin
          ptr_d  = owner_inc;
          hold_d = '0;
          if (any_win) begin
            gnt_d    = win;
            gnt_id_d = win_idx;
          end else begin
            gnt_d    = '0;
            gnt_id_d = '0;
            state_d  = StIdle;
          end
        end else if (!any_win) begin
          // Uncontended owner: counter saturates so a newcomer preempts promptly.
          if (LimitEn && hold_q != HoldLast) hold_d = hold_q + 1'b1;
        end else if (LimitEn && hold_q == HoldLast) begin
          ptr_d     = owner_inc;
          gnt_d     = win;
          gnt_id_d  = win_idx;
          hold_d    = '0;
          preempt_d = 1'b1;
        end else if (LimitEn) begin
          hold_d = hold_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      gnt_q     <= '0;
      gnt_id_q  <= '0;
      ptr_q     <= '0;
      hold_q    <= '0;
      preempt_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      gnt_id_q  <= gnt_id_d;
      ptr_q     <= ptr_d;
      hold_q    <= hold_d;
      preempt_q <= preempt_d;
    end
  end

  assign gnt_o       = gnt_q;
  assign gnt_valid_o = |gnt_q;
  assign gnt_id_o    = gnt_id_q;
  assign preempt_o   = preempt_q;

endmodule

// File: tb/tb_rr_hold_arbiter.sv
// Self-checking bench: integer reference model, fairness scoreboard, directed vectors.
module tb_rr_hold_arbiter;

  localparam int N          = 4;
  localparam int MAX_HOLD   = 8;
  localparam int IDW        = 2;
  localparam int WAIT_BOUND = (N - 1) * MAX_HOLD + 1;

  localparam logic [0:N-1] V0000 = 4'b0000;
  localparam logic [0:N-1] V1000 = 4'b1000;
  localparam logic [0:N-1] V0100 = 4'b0100;
  localparam logic [0:N-1] V0010 = 4'b0010;
  localparam logic [0:N-1] V0001 = 4'b0001;
  localparam logic [0:N-1] V1111 = 4'b1111;
  localparam logic [0:N-1] V0111 = 4'b0111;
  localparam logic [0:N-1] V0011 = 4'b0011;
  localparam logic [0:N-1] V1001 = 4'b1001;
  localparam logic [0:N-1] V1100 = 4'b1100;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic [0:N-1]   req = '0;
  logic [0:N-1]   gnt;
  logic           gnt_valid;
  logic [IDW-1:0] gnt_id;
  logic           preempt;

  rr_hold_arbiter #(
    .N        (N),
    .MAX_HOLD (MAX_HOLD)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .req_i       (req),
    .gnt_o       (gnt),
    .gnt_valid_o (gnt_valid),
    .gnt_id_o    (gnt_id),
    .preempt_o   (preempt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: current owner (-1 = none), search start, cycles owner has held.
  int m_owner = -1;
  int m_ptr   = 0;
  int m_held  = 0;
  bit m_pre   = 1'b0;
  int wait_cnt[N];

  task automatic chk(input string name, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  function automatic int search(input logic [0:N-1] r, input int start, input int excl);
    for (int k = 0; k < N; k++) begin
      int p;
      p = (start + k) % N;
      if (p != excl && r[p]) return p;
    end
    return -1;
  endfunction

  task automatic model_edge(input logic [0:N-1] r, input bit rst);
    int o;
    int nxt;
    m_pre = 1'b0;
    if (rst) begin
      m_owner = -1;
      m_ptr   = 0;
      m_held  = 0;
    end else if (m_owner < 0) begin
      nxt = search(r, m_ptr, -1);
      if (nxt >= 0) begin
        m_owner = nxt;
        m_held  = 1;
      end
    end else begin
      o   = m_owner;
      nxt = search(r, (o + 1) % N, o);
      if (!r[o]) begin
        m_ptr   = (o + 1) % N;
        m_owner = nxt;
        m_held  = (nxt >= 0) ? 1 : 0;
      end else if (nxt < 0) begin
        if (m_held < MAX_HOLD) m_held++;
      end else if (MAX_HOLD != 0 && m_held >= MAX_HOLD) begin
        m_ptr   = (o + 1) % N;
        m_owner = nxt;
        m_held  = 1;
        m_pre   = 1'b1;
      end else begin
        m_held++;
      end
    end
  endtask

  // One clock: apply inputs, advance model, compare every output and invariant.
  task automatic step(input logic [0:N-1] r, input bit rst);
    logic [0:N-1] g_before;
    logic [0:N-1] eg;
    req      = r;
    reset    = rst;
    g_before = gnt;
    @(posedge clk);
    model_edge(r, rst);
    for (int i = 0; i < N; i++) begin
      if (!rst && r[i] && !g_before[i]) wait_cnt[i]++;
      else wait_cnt[i] = 0;
    end
    #1;
    eg = '0;
    if (m_owner >= 0) eg[m_owner] = 1'b1;
    chk("model_gnt", int'(gnt), int'(eg));
    chk("model_gnt_id", int'(gnt_id), (m_owner >= 0) ? m_owner : 0);
    chk("model_gnt_valid", int'(gnt_valid), (m_owner >= 0) ? 1 : 0);
    chk("model_preempt", int'(preempt), int'(m_pre));
    chk("onehot_or_zero", ($countones(gnt) <= 1) ? 1 : 0, 1);
    chk("owner_is_requester", ((gnt & ~r) == '0) ? 1 : 0, 1);
    for (int i = 0; i < N; i++) begin
      chk("wait_bound", (wait_cnt[i] <= WAIT_BOUND) ? 1 : 0, 1);
    end
  endtask

  initial begin
    logic [0:N-1] r;
    for (int i = 0; i < N; i++) wait_cnt[i] = 0;

    // Reset state
    step(V0000, 1'b1);
    step(V0000, 1'b1);
    chk("reset_gnt", int'(gnt), int'(V0000));
    chk("reset_valid", int'(gnt_valid), 0);
    chk("reset_id", int'(gnt_id), 0);
    chk("reset_preempt", int'(preempt), 0);

    // First grant goes to bit 0 one cycle after request
    step(V1111, 1'b0);
    chk("first_gnt", int'(gnt), int'(V1000));
    chk("first_id", int'(gnt_id), 0);
    step(V1111, 1'b0);
    step(V1111, 1'b0);

    // Owner drops: handover with no idle cycle, wrap to bit 0 at the end
    step(V0111, 1'b0);
    chk("drop_gnt1", int'(gnt), int'(V0100));
    chk("drop_valid1", int'(gnt_valid), 1);
    step(V0011, 1'b0);
    chk("drop_gnt2", int'(gnt), int'(V0010));
    step(V0001, 1'b0);
    chk("drop_gnt3", int'(gnt), int'(V0001));
    chk("drop_id3", int'(gnt_id), 3);
    step(V1001, 1'b0);
    chk("drop_hold3", int'(gnt), int'(V0001));
    step(V1000, 1'b0);
    chk("wrap_gnt", int'(gnt), int'(V1000));
    chk("wrap_id", int'(gnt_id), 0);
    step(V0000, 1'b0);
    chk("release_idle", int'(gnt), int'(V0000));

    // Timeout: two contenders alternate every MAX_HOLD cycles
    step(V0000, 1'b1);
    for (int k = 1; k <= 2 * MAX_HOLD + 1; k++) begin
      step(V1100, 1'b0);
      if (k <= MAX_HOLD || k > 2 * MAX_HOLD) chk("timeout_gnt", int'(gnt), int'(V1000));
      else chk("timeout_gnt", int'(gnt), int'(V0100));
      chk("timeout_preempt", int'(preempt), (k == MAX_HOLD + 1 || k == 2 * MAX_HOLD + 1) ? 1 : 0);
    end

    // Sole requester keeps the grant indefinitely without preemption
    step(V0000, 1'b1);
    for (int k = 1; k <= 20; k++) begin
      step(V0010, 1'b0);
      chk("sole_gnt", int'(gnt), int'(V0010));
      chk("sole_preempt", int'(preempt), 0);
    end
    step(V0000, 1'b0);
    chk("sole_release_gnt", int'(gnt), int'(V0000));
    chk("sole_release_valid", int'(gnt_valid), 0);

    // Reset overrides an in-progress grant and restores pointer 0
    step(V0000, 1'b1);
    step(V0100, 1'b0);
    chk("mid_gnt", int'(gnt), int'(V0100));
    step(V1111, 1'b1);
    chk("mid_reset_gnt", int'(gnt), int'(V0000));
    step(V1111, 1'b0);
    chk("post_reset_gnt", int'(gnt), int'(V1000));
    chk("post_reset_id", int'(gnt_id), 0);

    // Random traffic with sticky requests so holds and timeouts occur
    r = '0;
    for (int c = 0; c < 10000; c++) begin
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 7) == 0) r[i] = ~r[i];
      end
      step(r, 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
